// File: rtl/picomips_core.sv
// picomips_core: single-cycle parametrised picoMIPS CPU.
//
// Executes one instruction per clock from an external combinational program
// ROM. The program-counter path supports a conditional branch (BEQZ), an
// unconditional jump (JMP) and HALT. IN stalls the core until the trigger
// switch rises. OUT copies a register to the LED output register.
//
// Instruction layout: {opcode[5:0], rd[RA-1:0], opd[n-1:0]}.
//
// Ports:
//   clk       - single clock; all state changes on the rising edge
//   reset     - synchronous, active-high; overrides every other condition
//   instr     - instruction word at prog_addr (combinational ROM)
//   prog_addr - current program counter
//   sw_data   - switch data captured by IN
//   sw_trig   - trigger switch; a rising edge completes a pending IN
//   led       - output register written by OUT
//   waiting   - high while stalled in IN (decoded from registered state)
//   halted    - high after HALT (decoded from registered state)
//
// Handshake: IN raises waiting and holds the PC. The stall completes on the
// first cycle in which trig_q == 0 and sw_trig == 1. In that cycle rd is
// written with sw_data and the PC advances. A trigger that was already high
// when IN was reached must fall and rise again before it counts.
module picomips_core #(
    parameter int n     = 8,
    parameter int Psize = 4,
    parameter int Rnum  = 4,
    localparam int RA    = $clog2(Rnum),
    localparam int Isize = 6 + RA + n
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [Isize-1:0] instr,
    output logic [Psize-1:0] prog_addr,
    input  logic [n-1:0]     sw_data,
    input  logic             sw_trig,
    output logic [n-1:0]     led,
    output logic             waiting,
    output logic             halted
);

    localparam logic [5:0] OP_ADD  = 6'b000001;
    localparam logic [5:0] OP_ADDI = 6'b000010;
    localparam logic [5:0] OP_SUB  = 6'b000011;
    localparam logic [5:0] OP_SUBI = 6'b000100;
    localparam logic [5:0] OP_MULI = 6'b000101;
    localparam logic [5:0] OP_IN   = 6'b000110;
    localparam logic [5:0] OP_OUT  = 6'b000111;
    localparam logic [5:0] OP_BEQZ = 6'b001000;
    localparam logic [5:0] OP_JMP  = 6'b001001;
    localparam logic [5:0] OP_HALT = 6'b001010;

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_WAIT = 2'd1,
        S_HLT  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [Psize-1:0] pc_q, pc_d;
    logic [n-1:0]     led_q, led_d;
    logic             trig_q;
    logic [n-1:0]     regs_q [Rnum];

    logic             wr_en;
    logic [n-1:0]     wr_data;

    // Instruction fields
    logic [5:0]       opcode;
    logic [RA-1:0]    rd;
    logic [n-1:0]     opd;
    logic [RA-1:0]    rs;
    logic [Psize-1:0] tgt;
    logic [n-1:0]     rd_val;
    logic [n-1:0]     rs_val;
    logic [Psize-1:0] pc_plus1;
    logic             trig_edge;

    // Q1.(n-1) fractional multiply: operands are sign-extended to 2n bits so
    // the product is exact; shifting right by n-1 and truncating to n bits
    // selects p[2n-2:n-1].
    logic signed [2*n-1:0] mul_a, mul_b, mul_p;

    assign opcode    = instr[Isize-1 -: 6];
    assign rd        = instr[n +: RA];
    assign opd       = instr[n-1:0];
    assign rs        = opd[RA-1:0];
    assign tgt       = opd[Psize-1:0];
    assign rd_val    = regs_q[rd];
    assign rs_val    = regs_q[rs];
    assign pc_plus1  = pc_q + Psize'(1);
    assign trig_edge = !trig_q && sw_trig;

    assign mul_a = $signed({{n{rd_val[n-1]}}, rd_val});
    assign mul_b = $signed({{n{opd[n-1]}}, opd});
    assign mul_p = mul_a * mul_b;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        led_d   = led_q;
        wr_en   = 1'b0;
        wr_data = '0;
        case (state_q)
            S_RUN: begin
                pc_d = pc_plus1;
                case (opcode)
                    OP_ADD:  begin wr_en = 1'b1; wr_data = rd_val + rs_val; end
                    OP_ADDI: begin wr_en = 1'b1; wr_data = rd_val + opd;    end
                    OP_SUB:  begin wr_en = 1'b1; wr_data = rd_val - rs_val; end
                    OP_SUBI: begin wr_en = 1'b1; wr_data = rd_val - opd;    end
                    OP_MULI: begin wr_en = 1'b1; wr_data = n'(mul_p >>> (n - 1)); end
                    OP_IN: begin
                        state_d = S_WAIT;
                        pc_d    = pc_q;
                    end
                    OP_OUT:  led_d = rd_val;
                    OP_BEQZ: if (rd_val == '0) pc_d = tgt;
                    OP_JMP:  pc_d = tgt;
                    OP_HALT: begin
                        state_d = S_HLT;
                        pc_d    = pc_q;
                    end
                    default: ;
                endcase
            end
            S_WAIT: begin
                // rd is re-decoded from instr every cycle; the ROM word at the
                // held PC must stay stable for the whole stall.
                if (trig_edge) begin
                    wr_en   = 1'b1;
                    wr_data = sw_data;
                    pc_d    = pc_plus1;
                    state_d = S_RUN;
                end
            end
            S_HLT: ;
            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_RUN;
            pc_q    <= '0;
            led_q   <= '0;
            trig_q  <= 1'b0;
            for (int i = 0; i < Rnum; i++) regs_q[i] <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            led_q   <= led_d;
            trig_q  <= sw_trig;
            if (wr_en) regs_q[rd] <= wr_data;
        end
    end

    assign prog_addr = pc_q;
    assign led       = led_q;
    assign waiting   = (state_q == S_WAIT);
    assign halted    = (state_q == S_HLT);

endmodule

// File: tb/tb_picomips_core.sv
// Testbench for picomips_core (n=8, Psize=4, Rnum=4, 16-bit instructions).
// The program ROM is an array inside the bench. An instruction-level model
// of the architecture is stepped alongside the DUT, and every cycle the
// outputs are compared against it. Directed steps also check the fixed
// values the programs must produce.
module tb_picomips_core;

    localparam int N  = 8;
    localparam int PS = 4;
    localparam int IS = 16;

    localparam logic [5:0] NOP  = 6'd0;
    localparam logic [5:0] ADD  = 6'd1;
    localparam logic [5:0] ADDI = 6'd2;
    localparam logic [5:0] SUB  = 6'd3;
    localparam logic [5:0] SUBI = 6'd4;
    localparam logic [5:0] MULI = 6'd5;
    localparam logic [5:0] IN   = 6'd6;
    localparam logic [5:0] OUT  = 6'd7;
    localparam logic [5:0] BEQZ = 6'd8;
    localparam logic [5:0] JMP  = 6'd9;
    localparam logic [5:0] HALT = 6'd10;

    logic          clk = 1'b0;
    logic          reset;
    logic [IS-1:0] instr;
    logic [PS-1:0] prog_addr;
    logic [N-1:0]  sw_data;
    logic          sw_trig;
    logic [N-1:0]  led;
    logic          waiting;
    logic          halted;

    logic [IS-1:0] rom [16];

    int checks   = 0;
    int failures = 0;

    // Architectural model: register values 0..255, PC 0..15,
    // mode 0 = running, 1 = waiting for trigger, 2 = halted.
    int m_reg [4];
    int m_pc;
    int m_led;
    int m_mode;
    int m_trig;

    always #5 clk = ~clk;

    assign instr = rom[prog_addr];

    picomips_core #(.n(N), .Psize(PS), .Rnum(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .instr     (instr),
        .prog_addr (prog_addr),
        .sw_data   (sw_data),
        .sw_trig   (sw_trig),
        .led       (led),
        .waiting   (waiting),
        .halted    (halted)
    );

    function automatic logic [IS-1:0] ins(input logic [5:0] op, input int r, input int v);
        logic [1:0] rr;
        logic [7:0] vv;
        rr = 2'(r);
        vv = 8'(v);
        return {op, rr, vv};
    endfunction

    function automatic int to_signed8(input int v);
        return (v >= 128) ? v - 256 : v;
    endfunction

    function automatic void model_step();
        logic [IS-1:0] w;
        int op, rd, opd, rs, tgt, nxt, p;
        int trig_rise;
        trig_rise = (m_trig == 0 && sw_trig == 1'b1) ? 1 : 0;
        if (reset) begin
            for (int i = 0; i < 4; i++) m_reg[i] = 0;
            m_pc = 0; m_led = 0; m_mode = 0; m_trig = 0;
            return;
        end
        w   = rom[m_pc];
        op  = int'(w[15:10]);
        rd  = int'(w[9:8]);
        opd = int'(w[7:0]);
        rs  = opd % 4;
        tgt = opd % 16;
        nxt = (m_pc + 1) % 16;
        if (m_mode == 0) begin
            m_pc = nxt;
            case (op)
                1: m_reg[rd] = (m_reg[rd] + m_reg[rs]) % 256;
                2: m_reg[rd] = (m_reg[rd] + opd) % 256;
                3: m_reg[rd] = (m_reg[rd] - m_reg[rs] + 256) % 256;
                4: m_reg[rd] = (m_reg[rd] - opd + 256) % 256;
                5: begin
                    p = to_signed8(m_reg[rd]) * to_signed8(opd);
                    m_reg[rd] = (p >>> 7) & 255;
                end
                6: begin m_mode = 1; m_pc = (nxt + 15) % 16; end
                7: m_led = m_reg[rd];
                8: if (m_reg[rd] == 0) m_pc = tgt;
                9: m_pc = tgt;
                10: begin m_mode = 2; m_pc = (nxt + 15) % 16; end
                default: ;
            endcase
        end else if (m_mode == 1) begin
            if (trig_rise == 1) begin
                m_reg[rd] = int'(sw_data);
                m_pc = nxt;
                m_mode = 0;
            end
        end
        m_trig = sw_trig ? 1 : 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        chk({tag, "_pc"},  32'(prog_addr), 32'(m_pc));
        chk({tag, "_led"}, 32'(led),       32'(m_led));
        chk({tag, "_wait"}, 32'(waiting),  32'(m_mode == 1));
        chk({tag, "_halt"}, 32'(halted),   32'(m_mode == 2));
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 16; i++) rom[i] = '0;
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        tick(tag);
        reset = 1'b0;
    endtask

    task automatic run_until_halt(input string tag, input int max_cycles);
        for (int i = 0; i < max_cycles && halted !== 1'b1; i++) tick(tag);
        chk({tag, "_reached_halt"}, 32'(halted), 32'd1);
    endtask

    initial begin
        int passes;
        logic [PS-1:0] prev;

        reset   = 1'b1;
        sw_trig = 1'b0;
        sw_data = '0;
        clear_rom();

        // Reset and arithmetic
        rom[0] = ins(ADDI, 1, 5);
        rom[1] = ins(ADDI, 2, 3);
        rom[2] = ins(ADD,  1, 2);
        rom[3] = ins(OUT,  1, 0);
        rom[4] = ins(HALT, 0, 0);
        tick("rst");
        tick("rst");
        chk("rst_pc", 32'(prog_addr), 32'd0);
        chk("rst_led", 32'(led), 32'd0);
        chk("rst_wait", 32'(waiting), 32'd0);
        chk("rst_halt", 32'(halted), 32'd0);
        reset = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick("arith");
            chk("arith_pc_seq", 32'(prog_addr), 32'(i));
            chk("arith_led", 32'(led), (i == 4) ? 32'd8 : 32'd0);
        end

        // Wrap and truncation
        clear_rom();
        rom[0] = ins(ADDI, 1, 250);
        rom[1] = ins(ADDI, 1, 10);
        rom[2] = ins(OUT,  1, 0);
        rom[3] = ins(SUBI, 0, 1);
        rom[4] = ins(OUT,  0, 0);
        rom[5] = ins(ADDI, 2, 8'h40);
        rom[6] = ins(MULI, 2, 8'hC0);
        rom[7] = ins(OUT,  2, 0);
        rom[8] = ins(HALT, 0, 0);
        do_reset("wrap_rst");
        repeat (3) tick("wrap");
        chk("wrap_add_led", 32'(led), 32'd4);
        repeat (2) tick("wrap");
        chk("wrap_subi_led", 32'(led), 32'hFF);
        repeat (3) tick("wrap");
        chk("wrap_muli_led", 32'(led), 32'hE0);
        tick("wrap");
        chk("wrap_halt", 32'(halted), 32'd1);

        // IN handshake with trigger already high
        clear_rom();
        rom[0] = ins(IN,   3, 0);
        rom[1] = ins(OUT,  3, 0);
        rom[2] = ins(HALT, 0, 0);
        sw_trig = 1'b1;
        do_reset("in_rst");
        for (int i = 0; i < 5; i++) begin
            tick("in_hold");
            chk("in_hold_wait", 32'(waiting), 32'd1);
            chk("in_hold_pc", 32'(prog_addr), 32'd0);
        end
        sw_trig = 1'b0;
        tick("in_low");
        chk("in_low_wait", 32'(waiting), 32'd1);
        sw_data = 8'h5A;
        sw_trig = 1'b1;
        tick("in_edge");
        chk("in_edge_wait", 32'(waiting), 32'd0);
        chk("in_edge_pc", 32'(prog_addr), 32'd1);
        tick("in_out");
        chk("in_out_led", 32'(led), 32'h5A);

        // Branch and loop
        clear_rom();
        rom[0] = ins(ADDI, 1, 3);
        rom[1] = ins(OUT,  1, 0);
        rom[2] = ins(SUBI, 1, 1);
        rom[3] = ins(BEQZ, 1, 6);
        rom[4] = ins(JMP,  0, 2);
        rom[5] = ins(NOP,  0, 0);
        rom[6] = ins(OUT,  1, 0);
        rom[7] = ins(HALT, 0, 0);
        sw_trig = 1'b0;
        do_reset("loop_rst");
        passes = 0;
        for (int i = 0; i < 40 && halted !== 1'b1; i++) begin
            if (prog_addr == 4'd2) passes++;
            tick("loop");
        end
        chk("loop_passes", 32'(passes), 32'd3);
        chk("loop_pc", 32'(prog_addr), 32'd7);
        chk("loop_led", 32'(led), 32'd0);
        chk("loop_halt", 32'(halted), 32'd1);

        // PC wrap over 16 NOPs
        clear_rom();
        do_reset("nop_rst");
        for (int i = 0; i < 20; i++) begin
            prev = prog_addr;
            tick("nop");
            if (prev == 4'd15) chk("nop_wrap", 32'(prog_addr), 32'd0);
        end

        // HALT holds everything while sw_trig toggles
        rom[0] = ins(ADDI, 0, 7);
        rom[1] = ins(OUT,  0, 0);
        rom[2] = ins(HALT, 0, 0);
        do_reset("hlt_rst");
        run_until_halt("hlt", 10);
        for (int i = 0; i < 12; i++) begin
            sw_trig = ~sw_trig;
            sw_data = N'($urandom);
            tick("hlt_hold");
            chk("hlt_halted", 32'(halted), 32'd1);
            chk("hlt_pc", 32'(prog_addr), 32'd2);
            chk("hlt_led", 32'(led), 32'd7);
        end
        reset = 1'b1;
        tick("hlt_exit");
        chk("hlt_exit_halted", 32'(halted), 32'd0);
        chk("hlt_exit_pc", 32'(prog_addr), 32'd0);
        reset = 1'b0;

        // Reset while waiting, with a trigger edge in the reset cycle
        clear_rom();
        rom[0] = ins(ADDI, 0, 9);
        rom[1] = ins(ADDI, 1, 4);
        rom[2] = ins(OUT,  0, 0);
        rom[3] = ins(IN,   2, 0);
        rom[4] = ins(HALT, 0, 0);
        sw_trig = 1'b0;
        do_reset("rw_rst");
        for (int i = 0; i < 10 && waiting !== 1'b1; i++) tick("rw_run");
        chk("rw_waiting", 32'(waiting), 32'd1);
        chk("rw_led_before", 32'(led), 32'd9);
        reset   = 1'b1;
        sw_trig = 1'b1;
        sw_data = 8'hAA;
        tick("rw_reset");
        chk("rw_pc", 32'(prog_addr), 32'd0);
        chk("rw_led", 32'(led), 32'd0);
        chk("rw_wait", 32'(waiting), 32'd0);
        reset   = 1'b0;
        sw_trig = 1'b0;
        clear_rom();
        rom[0] = ins(OUT,  0, 0);
        rom[1] = ins(ADDI, 3, 1);
        rom[2] = ins(OUT,  3, 0);
        rom[3] = ins(OUT,  1, 0);
        rom[4] = ins(OUT,  3, 0);
        rom[5] = ins(OUT,  2, 0);
        rom[6] = ins(HALT, 0, 0);
        tick("rw_chk");
        chk("rw_r0", 32'(led), 32'd0);
        repeat (2) tick("rw_chk");
        chk("rw_r3", 32'(led), 32'd1);
        tick("rw_chk");
        chk("rw_r1", 32'(led), 32'd0);
        repeat (2) tick("rw_chk");
        chk("rw_r2", 32'(led), 32'd0);

        // Random programs, triggers, data and occasional resets
        for (int prg = 0; prg < 5; prg++) begin
            for (int a = 0; a < 16; a++) begin
                int sel;
                logic [5:0] op;
                sel = int'($urandom_range(0, 15));
                if (sel <= 11) op = 6'(sel);
                else if (sel <= 13) op = OUT;
                else op = 6'($urandom_range(0, 63));
                if (op == HALT && $urandom_range(0, 3) != 0) op = ADDI;
                rom[a] = ins(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 255)));
            end
            do_reset("rnd_rst");
            for (int c = 0; c < 150; c++) begin
                if ($urandom_range(0, 2) == 0) sw_trig = ~sw_trig;
                sw_data = N'($urandom);
                reset = ($urandom_range(0, 60) == 0);
                tick("rnd");
            end
            reset = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/picomips_core.md
# picomips_core

Parametrised successor to the single-cycle picoMIPS CPU. It adds a configurable data width, register count and program depth, and a program-counter control path with branches, jumps and halt. The switch read becomes a handshaked `IN` instruction that stalls until the trigger switch rises. Results go to `led` through an explicit `OUT` instruction rather than a raw ALU tap. The core sits between an external combinational program ROM (`prog`) and the board switches/LEDs.

## Interface
- `n`, 8: data width; registers, ALU, immediates, switches and LEDs are all n bits.
- `Psize`, 4: program address width; up to 2^Psize instructions. Constraint: Psize <= n.
- `Rnum`, 4: number of general registers. RA = $clog2(Rnum) address bits.
- Derived `Isize` = 6 + RA + n. Instruction layout is {opcode[5:0], rd[RA-1:0], opd[n-1:0]}.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `instr` input Isize: instruction at `prog_addr`, from combinational ROM.
- `prog_addr` output Psize: current PC.
- `sw_data` input n: switch data read by `IN`.
- `sw_trig` input 1: trigger switch; a rising edge completes a pending `IN`.
- `led` output n: output register, written by `OUT`.
- `waiting` output 1: high while the core is stalled in `IN`.
- `halted` output 1: high after `HALT` executes.

## Operation
- `rs` = opd[RA-1:0]. `imm` = opd. `tgt` = opd[Psize-1:0]. All arithmetic is modulo 2^n and no flags are kept.
- Opcodes:
  - 000000 NOP.
  - 000001 ADD: rd = rd + rs.
  - 000010 ADDI: rd = rd + imm.
  - 000011 SUB: rd = rd - rs.
  - 000100 SUBI: rd = rd - imm.
  - 000101 MULI: signed rd × signed imm gives a 2n-bit product p; rd = p[2n-2:n-1] (Q1.(n-1) fractional multiply, truncated). The single overflow case, -1 × -1, yields 2^(n-1) and is accepted.
  - 000110 IN: stall; on trigger edge, rd = sw_data.
  - 000111 OUT: led = rd.
  - 001000 BEQZ: if rd == 0 then PC = tgt, else PC+1.
  - 001001 JMP: PC = tgt.
  - 001010 HALT.
  - All other opcodes execute as NOP.
- PC increments modulo 2^Psize, so the last address wraps to 0.
- FSM states:
  - RUN: executes one instruction per cycle.
    - `IN` moves to WAIT with PC held and no write.
    - `HALT` moves to HLT with PC held.
  - WAIT: `waiting` = 1; PC is frozen.
    - On a trigger edge (trig_q == 0 and sw_trig == 1), write sw_data to rd, set PC = PC+1, go to RUN.
    - The instruction is re-decoded from `instr` each cycle, so the ROM must be stable.
  - HLT: `halted` = 1. No writes occur and PC is frozen. Only reset exits this state.
- Trigger edge detector: trig_q <= sw_trig every cycle, in every state.
  - A trigger already high when `IN` is reached does not count; it must go low and then high again.
  - An edge that occurs while in RUN is discarded.
- Register 0 is an ordinary register and is not hardwired to zero.

## Timing
- Reset values:
  - PC = 0 and state = RUN.
  - All registers = 0.
  - led = 0 and trig_q = 0.
  - waiting = 0 and halted = 0.
- Reset overrides every other condition, including in WAIT and HLT. It takes effect on the first clk edge at which it is sampled high.
- Single-cycle execution: `prog_addr` comes directly from the PC register, `instr` is used combinationally, and the register write, PC update and led update all land on the same edge.
- Read-after-write across consecutive instructions sees the new value. There are no hazards.
- `led` changes on the edge that ends the `OUT` cycle.
- `IN` latency: at least 2 cycles.
  - Cycle k: `IN` is decoded and the core enters WAIT.
  - Edge detected in cycle m > k: rd is written and PC advances on the edge ending cycle m.
- `waiting` and `halted` are decoded from the registered state, so they are glitch-free.
- A taken branch takes effect on the next edge, with no delay slot.

## Test plan
- Reset and arithmetic: reset for 2 cycles, then run ADDI r1,5; ADDI r2,3; ADD r1,r2; OUT r1. Required: led = 0 until OUT, then 8; prog_addr = 0,1,2,3,4 on consecutive cycles.
- Wrap and truncation: ADDI r1,250; ADDI r1,10; OUT r1 → led = 4. SUBI r0,1 from 0 → r0 = 255. MULI with r = 0x40 (0.5) and imm = 0xC0 (-0.5) → 0xE0 (-0.25).
- IN handshake:
  - Hold sw_trig = 1 before IN → waiting stays 1 and PC is frozen.
  - Drop sw_trig to 0, then raise it with sw_data = 0x5A → r = 0x5A on that edge, waiting = 0, PC+1.
  - Following OUT → led = 0x5A.
- Branch and loop: r1 = 3; loop of SUBI r1,1 then BEQZ r1,done then JMP loop. Required: exactly 3 passes, PC lands at done, and OUT r1 gives 0.
- HALT and PC wrap:
  - Program with 16 NOPs → prog_addr cycles 15 → 0.
  - After HALT: halted = 1, prog_addr constant, and led unchanged for ≥10 cycles despite sw_trig toggling.
  - Reset → halted = 0 and PC = 0.
- Reset mid-WAIT: assert reset while waiting = 1 with registers nonzero. Required: next cycle all state returns to reset values, and a trigger edge in that cycle writes nothing.
